// File: rtl/serial_parity_receiver_pkg.sv
// Shared definitions for the even-parity serial receiver: FSM encoding and line levels.
package serial_parity_receiver_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/serial_parity_receiver_bit_tick_counter.sv
// Loadable down-counter that flags expiry for one cycle when it reaches zero while enabled.
module bit_tick_counter #(
  parameter int unsigned cnt_w = 4
) (
  input  logic             clk,
  input  logic             rst_x,
  input  logic             load,
  input  logic             en,
  input  logic [cnt_w-1:0] load_val,
  output logic             expired_c
);

  logic [cnt_w-1:0] count_q;

  // Holds at zero once expired; the FSM reloads on every transition that needs another sample.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - cnt_w'(1);
    end
  end

  assign expired_c = en && (count_q == '0);

endmodule

// File: rtl/serial_parity_receiver.sv
// Even-parity serial receiver: start, LSB-first data, parity, stop; one-cycle strobe per frame.
module serial_parity_receiver
  import serial_parity_receiver_pkg::*;
#(
  parameter int unsigned width   = 8,
  parameter int unsigned divisor = 16
) (
  input  logic             clk,
  input  logic             rst_x,
  input  logic             i_rx,
  output logic [width-1:0] o_data,
  output logic             o_valid,
  output logic             o_parity_error,
  output logic             o_frame_error,
  output logic             o_busy
);

  localparam int unsigned HALF  = divisor / 2;
  localparam int unsigned CNT_W = $clog2(divisor);
  localparam int unsigned IDX_W = (width > 1) ? $clog2(width) : 1;

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] DIV_M1   = CNT_W'(divisor - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(width - 1);

  rx_state_t        state_q, state_d;
  logic             rx_meta, rx_s;
  logic [width-1:0] shift_q, shift_nxt;
  logic [IDX_W-1:0] bit_idx_q;
  logic             parity_q;

  logic             tmr_load, tmr_en, tmr_exp_c;
  logic [CNT_W-1:0] tmr_val;
  logic             shift_en, parity_en, out_en;

  // Two-flop synchronizer; resets to idle level so no false start after reset.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      rx_meta <= LINE_IDLE;
      rx_s    <= LINE_IDLE;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  bit_tick_counter #(
    .cnt_w(CNT_W)
  ) u_tick (
    .clk      (clk),
    .rst_x    (rst_x),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .expired_c(tmr_exp_c)
  );

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    tmr_val   = DIV_M1;
    shift_en  = 1'b0;
    parity_en = 1'b0;
    out_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_s != LINE_IDLE) begin
          state_d  = START;
          tmr_load = 1'b1;
          tmr_val  = HALF_M1;
        end
      end
      START: begin
        tmr_en = 1'b1;
        if (tmr_exp_c) begin
          if (rx_s == LINE_IDLE) begin
            state_d = IDLE;
          end else begin
            state_d  = DATA;
            tmr_load = 1'b1;
          end
        end
      end
      DATA: begin
        tmr_en = 1'b1;
        if (tmr_exp_c) begin
          shift_en = 1'b1;
          tmr_load = 1'b1;
          if (bit_idx_q == LAST_IDX) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        tmr_en = 1'b1;
        if (tmr_exp_c) begin
          parity_en = 1'b1;
          tmr_load  = 1'b1;
          state_d   = STOP;
        end
      end
      STOP: begin
        tmr_en = 1'b1;
        if (tmr_exp_c) begin
          out_en  = 1'b1;
          state_d = (rx_s == LINE_IDLE) ? IDLE : BREAK;
        end
      end
      BREAK: begin
        if (rx_s == LINE_IDLE) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // First received bit ends up in bit 0 after width shifts.
  if (width == 1) begin : g_shift_one
    assign shift_nxt = rx_s;
  end else begin : g_shift_many
    assign shift_nxt = {rx_s, shift_q[width-1:1]};
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      shift_q   <= '0;
      bit_idx_q <= '0;
      parity_q  <= 1'b0;
    end else begin
      if (shift_en) begin
        shift_q   <= shift_nxt;
        bit_idx_q <= bit_idx_q + IDX_W'(1);
      end else if (state_q != DATA) begin
        bit_idx_q <= '0;
      end
      if (parity_en) begin
        parity_q <= rx_s;
      end
    end
  end

  // Word and flags change only together with the strobe.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      o_data         <= '0;
      o_valid        <= 1'b0;
      o_parity_error <= 1'b0;
      o_frame_error  <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      o_valid <= out_en;
      o_busy  <= (state_d != IDLE);
      if (out_en) begin
        o_data         <= shift_q;
        o_parity_error <= (^shift_q) ^ parity_q;
        o_frame_error  <= ~rx_s;
      end
    end
  end

endmodule

// File: tb/tb_serial_parity_receiver.sv
// Scoreboard bench for serial_parity_receiver: directed scenarios plus randomized frames.
module tb_serial_parity_receiver;

  localparam int unsigned W    = 8;
  localparam int unsigned DIV  = 8;
  localparam int unsigned HALF = DIV / 2;
  // Drive edge -> o_valid edge: 2 sync flops, 1 detect cycle, half period, (W+2) periods.
  localparam int unsigned LAT  = 3 + HALF + (W + 2) * DIV;

  logic         clk   = 1'b0;
  logic         rst_x = 1'b0;
  logic         i_rx  = 1'b1;
  logic [W-1:0] o_data;
  logic         o_valid;
  logic         o_parity_error;
  logic         o_frame_error;
  logic         o_busy;

  serial_parity_receiver #(
    .width  (W),
    .divisor(DIV)
  ) dut (
    .clk           (clk),
    .rst_x         (rst_x),
    .i_rx          (i_rx),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .o_parity_error(o_parity_error),
    .o_frame_error (o_frame_error),
    .o_busy        (o_busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int errors  = 0;
  int checks  = 0;
  int n_valid = 0;

  typedef struct {
    logic [W-1:0] data;
    logic         pe;
    logic         fe;
    int unsigned  at_cyc;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding frame.
  always @(negedge clk) begin
    exp_t e;
    if (rst_x && o_valid) begin
      n_valid++;
      check("valid_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("data",         32'(o_data),         32'(e.data));
        check("parity_error", 32'(o_parity_error), 32'(e.pe));
        check("frame_error",  32'(o_frame_error),  32'(e.fe));
        check("valid_cycle",  cyc,                 e.at_cyc);
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    i_rx = b;
    tick(DIV);
  endtask

  // Transmit one frame; expectation follows directly from the frame contents.
  task automatic send_frame(input logic [W-1:0] d, input logic pbit, input logic stopb,
                            input int unsigned low_extra, input int unsigned gap);
    exp_t e;
    e.data   = d;
    e.pe     = (^d) ^ pbit;
    e.fe     = ~stopb;
    e.at_cyc = cyc + LAT;
    sb.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < int'(W); i++) drive_bit(d[i]);
    drive_bit(pbit);
    drive_bit(stopb);
    if (!stopb) begin
      i_rx = 1'b0;
      tick(low_extra);
      check("break_busy", 32'(o_busy), 32'd1);
    end
    i_rx = 1'b1;
    tick(gap);
  endtask

  initial begin
    int unsigned e0;
    int          nv0;
    logic [W-1:0] d;
    logic         pb, sb_bit;
    int unsigned  extra, gap;

    rst_x = 1'b0;
    i_rx  = 1'b1;
    tick(3);
    check("rst_data",   32'(o_data),         32'd0);
    check("rst_valid",  32'(o_valid),        32'd0);
    check("rst_perr",   32'(o_parity_error), 32'd0);
    check("rst_ferr",   32'(o_frame_error),  32'd0);
    check("rst_busy",   32'(o_busy),         32'd0);
    rst_x = 1'b1;
    tick(4);

    // Clean frame
    send_frame(8'hA5, 1'b0, 1'b1, 0, 10);
    check("clean_busy_after", 32'(o_busy), 32'd0);

    // Parity error, then cleared by the next good frame
    send_frame(8'h01, 1'b0, 1'b1, 0, 5);
    send_frame(8'h03, 1'b0, 1'b1, 0, 5);

    // Framing error with line held low
    send_frame(8'hFF, 1'b0, 1'b0, 30, 6);
    check("break_exit_busy", 32'(o_busy), 32'd0);

    // Glitch shorter than half a bit
    e0 = cyc;
    i_rx = 1'b0;
    tick(2);
    i_rx = 1'b1;
    tick(4);
    check("glitch_start_busy", 32'(o_busy), 32'd1);
    tick(1);
    check("glitch_idle_busy", 32'(o_busy), 32'd0);
    check("glitch_cycle", cyc - e0, 32'd7);
    tick(10);

    // Back-to-back frames with correct parity
    nv0 = n_valid;
    send_frame(8'h12, ^8'h12, 1'b1, 0, 0);
    send_frame(8'h34, ^8'h34, 1'b1, 0, 0);
    send_frame(8'h56, ^8'h56, 1'b1, 0, 20);
    check("b2b_count", 32'(n_valid - nv0), 32'd3);

    // Reset in the middle of data bit 3
    d = 8'hC9;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    i_rx = d[3];
    tick(DIV / 2);
    check("busy_mid_frame", 32'(o_busy), 32'd1);
    rst_x = 1'b0;
    #1;
    check("mid_rst_data",  32'(o_data),         32'd0);
    check("mid_rst_valid", 32'(o_valid),        32'd0);
    check("mid_rst_perr",  32'(o_parity_error), 32'd0);
    check("mid_rst_ferr",  32'(o_frame_error),  32'd0);
    check("mid_rst_busy",  32'(o_busy),         32'd0);
    i_rx = 1'b1;
    tick(2);
    rst_x = 1'b1;
    tick(3);
    send_frame(8'h5A, 1'b0, 1'b1, 0, 10);

    // Randomized frames: parity faults, framing faults, variable gaps
    for (int n = 0; n < 40; n++) begin
      d      = W'($urandom_range(0, (1 << W) - 1));
      pb     = (^d) ^ ($urandom_range(0, 3) == 0);
      sb_bit = ($urandom_range(0, 5) != 0);
      extra  = $urandom_range(0, 20);
      gap    = sb_bit ? $urandom_range(0, 12) : $urandom_range(2, 12);
      send_frame(d, pb, sb_bit, extra, gap);
    end

    tick(20);
    check("scoreboard_drained", sb.size(), 32'd0);
    check("final_busy", 32'(o_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_parity_receiver.md
# serial_parity_receiver

Serial receiver for the even-parity link. It recovers fixed-width words from an asynchronous one-wire serial line framed as start bit, data LSB first, even-parity bit, stop bit. It checks the parity bit against the received data and the stop bit against idle level, then presents each word with error flags as a one-cycle strobe to downstream logic. It is the receive-side partner of the transmit path, which appends the XOR of the data bits as the parity bit.

## Interface
- `width`, default 8: data bits per frame; 1..16.
- `divisor`, default 16: clocks per serial bit period; ≥ 4. Half-period = floor(`divisor`/2).

- `clk`  in  1  single clock; every register is on its rising edge.
- `rst_x`  in  1  reset; asynchronous, active-low.
- `i_rx`  in  1  serial line, asynchronous to `clk`; idle level 1.
- `o_data`  out  `width`  last received word; reset 0.
- `o_valid`  out  1  one-cycle strobe, new frame complete; reset 0.
- `o_parity_error`  out  1  XOR of the received data and parity bits is 1; reset 0.
- `o_frame_error`  out  1  sampled stop bit was 0; reset 0.
- `o_busy`  out  1  high in any state other than IDLE; reset 0.

## Operation
- `i_rx` passes through a 2-flop synchronizer that resets to 1. The result is `rx_s`, and all logic uses `rx_s` only.
- States:
  - IDLE
    - `rx_s`==0 → START, bit timer loaded with half-period−1.
  - START
    - At timer expiry, if `rx_s`==1 (false start) → IDLE with no output.
    - Otherwise → DATA, timer = `divisor`−1, bit index = 0.
  - DATA
    - At each expiry, shift `rx_s` into the shift register MSB-side, so the first received bit ends in bit 0.
    - After the bit at index `width`−1 → PARITY.
  - PARITY
    - At expiry, latch `rx_s` as parity bit → STOP.
  - STOP
    - At expiry, load `o_data` with the shift register.
    - Set `o_parity_error` = XOR of the shift register and the parity bit.
    - Set `o_frame_error` = ~`rx_s`.
    - Pulse `o_valid`.
    - Next state: IDLE if `rx_s`==1, else BREAK.
  - BREAK
    - Wait for `rx_s`==1 → IDLE.
    - No start detection while in BREAK.
- `o_data` and both error flags hold their values until the next STOP sample. They change only in the same cycle as `o_valid`.
- There is no ready or backpressure. A consumer that misses the `o_valid` strobe loses the word.
- Timer reload: every state transition that expects another sample reloads the timer to `divisor`−1. The timer never free-runs in IDLE or BREAK.

## Timing
- Let t0 be the first cycle in which IDLE sees `rx_s`==0. t0 is 2 clocks after the falling edge at `i_rx` is sampled.
- Sample points:
  - start check at t0+half
  - data bit k at t0+half+(k+1)·`divisor`
  - parity at t0+half+(`width`+1)·`divisor`
  - stop at t0+half+(`width`+2)·`divisor`
- `o_valid`, `o_data` and the flags are registered and visible the cycle after the stop sample.
- Back-to-back frames: a start bit that begins immediately after the stop period is detected. IDLE is re-entered one cycle after the stop sample, which is well inside the stop bit.
- Asserting `rst_x` mid-frame discards the partial word and forces all outputs to their reset values immediately. After release, the block is in IDLE with `rx_s`=1 and needs 2 clocks of synchronizer fill before detecting a start.

## Structure
- Shared package holds:
  - the state encoding constants IDLE, START, DATA, PARITY, STOP, BREAK (3 bits)
  - the line idle level constant (1)
- One natural sub-module is `bit_tick_counter`. It is a down-counter with a load input and a one-cycle expiry output; its width is ceil(log2(`divisor`)).
- Synchronizer, shift register, bit index and FSM stay in the top module.

## Test plan
All scenarios use `width`=8, `divisor`=8 and the standard frame timing unless noted.
- Clean frame: 0xA5 with parity 0 and stop 1 → one `o_valid` pulse at t0+4+80+1, `o_data`=0xA5, both errors 0, `o_busy` low again afterwards.
- Parity error: 0x01 sent with parity 0 → `o_data`=0x01, `o_parity_error`=1, `o_frame_error`=0. The next clean frame 0x03 with parity 0 clears the flag.
- Framing error: 0xFF with parity 0 and stop 0, line held low 30 clocks → `o_frame_error`=1. State stays BREAK with `o_busy`=1 until the line returns high; no second `o_valid`.
- Glitch: `i_rx` low for 2 clocks, then high → no `o_valid`, and the FSM returns to IDLE at t0+4.
- Back-to-back: 0x12, 0x34, 0x56 with no idle gap → exactly three `o_valid` pulses, spaced 88 clocks apart, with the correct data and no errors.
- Reset mid-frame: assert `rst_x` during DATA bit 3 → all outputs 0 immediately. After release, a clean frame 0x5A is received correctly.
